operand_accumulator: RTL
========================

# operand_accumulator

Sequential front-end stage that collects a frame of COUNT unsigned operands over a valid/ready input, sums them with saturation, and presents one result per frame with a sticky overflow flag. It sits directly upstream of the combinational adder/result path (a, b → result). It replaces an unchecked WIDTH-bit wrap-around sum with a registered, overflow-aware result. The block is lint-clean by construction: full case coverage, no inferred latches, and a single driver per register.

## Interface
- WIDTH, 4: operand and sum width in bits (≥2).
- COUNT, 4: operands per frame (1..255).
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  WIDTH  unsigned operand.
- out_valid  output  1  frame result available.
- out_ready  input  1  downstream consumes result this cycle.
- out_sum  output  WIDTH  saturated frame sum.
- out_overflow  output  1  at least one addition in the frame saturated.
- frame_count  output  8  number of completed output handshakes, wraps at 256.

## Operation
- Input accept: in_valid && in_ready at a rising edge. Output handshake: out_valid && out_ready at a rising edge.
- State machine, registered, 2-bit encoding, all four codes decoded; the unused code recovers to IDLE on the next edge:
  - IDLE: in_ready=1, out_valid=0.
    - On accept: sum←in_data, ovf←0, cnt←1.
    - Go to HOLD if COUNT==1, else to ACCUM.
  - ACCUM: in_ready=1, out_valid=0.
    - On accept: sum←sat(sum+in_data), ovf←ovf | carry, cnt←cnt+1.
    - Go to HOLD when cnt+1==COUNT.
  - HOLD: in_ready=0, out_valid=1.
    - On output handshake: frame_count←frame_count+1, sum←0, ovf←0, cnt←0; go to IDLE.
- Arithmetic:
  - The addition is performed at WIDTH+1 bits; carry = MSB.
  - If carry=1, sum←{WIDTH{1'b1}}. Otherwise sum←low WIDTH bits.
  - ovf is sticky within a frame.
- cnt is 8 bits wide and never exceeds COUNT.
- out_sum and out_overflow are driven directly from the sum and ovf registers. They are meaningful only while out_valid=1.
- frame_count is modulo-256: 255→0 on the next handshake.
- No state advances in ACCUM or IDLE without an accept. Gaps in in_valid are legal and lose no data.

## Timing
- Reset (async assert, synchronous release at the next edge):
  - state=IDLE, sum=0, ovf=0, cnt=0, frame_count=0.
  - Hence in_ready=1, out_valid=0, out_sum=0, out_overflow=0.
- Latency: out_valid rises on the first edge after the COUNT-th accept, with one cycle of register latency. Minimum frame period is COUNT+1 cycles.
- Handshake rules:
  - in_ready is a pure function of state; it does not depend combinationally on in_valid or out_ready.
  - While out_valid=1 and out_ready=0, out_sum, out_overflow and out_valid hold stable.
  - Once out_valid rises, it stays high until the handshake.
- Simultaneous events:
  - in_valid in HOLD is ignored (in_ready=0).
  - An accept cannot coincide with an output handshake, because the two occur in disjoint states.
  - A new frame starts in IDLE on the cycle after the handshake.
- Reset mid-frame or in HOLD discards the partial or pending result immediately. frame_count does not increment.
- out_ready asserted outside HOLD has no effect.

## Test plan
- WIDTH=4, COUNT=4; accept 1,2,3,4 on consecutive cycles with out_ready=1 → out_valid=1 one cycle after the 4th accept, out_sum=10, out_overflow=0, frame_count=1 after the handshake.
- Inputs 8,8,1,1 → carry on the 2nd add (16), sum saturates to 15 and stays 15 → out_sum=15, out_overflow=1.
- Inputs 5,5,5,5 with out_ready=0 for 6 cycles → out_valid held, out_sum=15 and out_overflow=1 stable, in_ready=0 throughout, a driven in_valid=1 with data 7 is not absorbed. Then out_ready=1 → IDLE, and the next frame starts from sum=0.
- Inputs 2,(gap 3 cycles),3,(gap),1,4 → out_sum=10. in_ready stays 1 during the gaps, and cnt advances only on accepts.
- Assert rst after 2 accepts (values 6,6) → outputs immediately go to their reset values. A following frame 1,1,1,1 → out_sum=4, out_overflow=0, frame_count=1.
- Complete 256 frames of 0,0,0,0 → frame_count wraps 255→0 on the 256th handshake. COUNT=1 build: a single accept of 9 → out_valid on the next edge, out_sum=9.

Source files
------------

// File: rtl/operand_accumulator.sv
// operand_accumulator: collects COUNT unsigned operands over a valid/ready
// input, sums them with saturation, and holds one registered result per frame
// together with a sticky overflow flag and a modulo-256 completed-frame counter.
module operand_accumulator #(
    parameter int WIDTH = 4,
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_overflow,
    output logic [7:0]       frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_HOLD  = 2'b10,
        ST_SPARE = 2'b11
    } state_e;

    localparam logic [7:0] COUNT_C  = 8'(COUNT);
    localparam bit         SINGLE_C = (COUNT == 1);

    state_e           state_q;
    logic [WIDTH-1:0] sum_q;
    logic             ovf_q;
    logic [7:0]       cnt_q;
    logic [7:0]       frame_count_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             accept;
    logic             handshake;
    logic [WIDTH:0]   add_wide;
    logic [WIDTH-1:0] sum_d;
    logic             carry_d;
    logic [7:0]       cnt_d;
    logic             last_d;

    assign accept    = in_valid && in_ready_q;
    assign handshake = out_valid_q && out_ready;

    // Saturating accumulate: add at WIDTH+1 bits, clamp to all-ones on carry.
    // NOTE: every always_comb output is assigned a default first, so no latch can be inferred.
    always_comb begin
        add_wide = '0;
        sum_d    = '0;
        carry_d  = 1'b0;
        cnt_d    = '0;
        last_d   = 1'b0;
        add_wide = {1'b0, sum_q} + {1'b0, in_data};
        carry_d  = add_wide[WIDTH];
        sum_d    = carry_d ? {WIDTH{1'b1}} : add_wide[WIDTH-1:0];
        cnt_d    = cnt_q + 8'd1;
        last_d   = (cnt_d == COUNT_C);
    end

    // Frame FSM with its datapath registers and registered handshake outputs.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sum_q         <= '0;
            ovf_q         <= 1'b0;
            cnt_q         <= '0;
            frame_count_q <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        sum_q <= in_data;
                        ovf_q <= 1'b0;
                        cnt_q <= 8'd1;
                        if (SINGLE_C) begin
                            state_q     <= ST_HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        sum_q <= sum_d;
                        ovf_q <= ovf_q | carry_d;
                        cnt_q <= cnt_d;
                        if (last_d) begin
                            state_q     <= ST_HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (handshake) begin
                        frame_count_q <= frame_count_q + 8'd1;
                        sum_q         <= '0;
                        ovf_q         <= 1'b0;
                        cnt_q         <= '0;
                        state_q       <= ST_IDLE;
                        in_ready_q    <= 1'b1;
                        out_valid_q   <= 1'b0;
                    end
                end
                default: begin
                    // Unused encoding: recover to a clean IDLE.
                    state_q     <= ST_IDLE;
                    sum_q       <= '0;
                    ovf_q       <= 1'b0;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_sum      = sum_q;
    assign out_overflow = ovf_q;
    assign frame_count  = frame_count_q;

endmodule
